// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator sequencer: integrator/comb enables, priming and output handshake
//
// Purpose: drives the enables of a CIC integrator chain (input rate) and comb chain
// (decimated rate). It carries no datapath.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   enable        level-sensitive run request
//   in_valid      input sample present this cycle
//   cfg_rate      decimation ratio R (values below 2 are forced to 2)
//   cfg_load      one-cycle pulse capturing cfg_rate into the pending ratio
//   out_ready     downstream accepts the decimated output
//   integ_en      integrator update enable (in_valid delayed one cycle)
//   integ_clr     synchronous clear of integrator and comb registers
//   comb_en       decimation strobe, one cycle per R accepted samples
//   out_valid     decimated output valid, held until out_ready
//   overrun       sticky: an output was replaced before acceptance
//   cfg_err       sticky: an illegal ratio was loaded
//   busy          sequencer not idle
module cic_decim_ctrl #(
    parameter int RATE_W   = 8,
    parameter int NSTAGES  = 5,
    parameter int COMB_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic              cfg_load,
    input  logic              out_ready,
    output logic              integ_en,
    output logic              integ_clr,
    output logic              comb_en,
    output logic              out_valid,
    output logic              overrun,
    output logic              cfg_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, FLUSH, PRIME, RUN} state_t;

    localparam int CNT_W = $clog2(NSTAGES + 1);

    state_t              state_q, state_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   pend_q, pend_d;
    logic [RATE_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]    strobe_cnt_q, strobe_cnt_d;
    logic [COMB_LAT-1:0] dline_q, dline_d;
    logic                integ_en_q, integ_en_d;
    logic                integ_clr_q, integ_clr_d;
    logic                comb_en_q, comb_en_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                cfg_err_q, cfg_err_d;
    logic                busy_q, busy_d;
    logic                fire;
    logic                arrive;

    always_comb begin
        state_d      = state_q;
        rate_d       = rate_q;
        pend_d       = pend_q;
        phase_d      = phase_q;
        flush_cnt_d  = flush_cnt_q;
        strobe_cnt_d = strobe_cnt_q;
        dline_d      = dline_q << 1;
        integ_en_d   = 1'b0;
        comb_en_d    = 1'b0;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q;
        cfg_err_d    = cfg_err_q;
        fire         = 1'b0;
        arrive       = dline_q[COMB_LAT-1];

        if (!enable) begin
            state_d = IDLE;
            dline_d = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rate_d      = pend_q;
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                    overrun_d   = 1'b0;
                    cfg_err_d   = 1'b0;
                end
                FLUSH: begin
                    if (flush_cnt_q == CNT_W'(NSTAGES - 1)) begin
                        state_d      = PRIME;
                        phase_d      = '0;
                        strobe_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    integ_en_d = in_valid;
                    // Compare before increment so R = 2^RATE_W-1 never overflows phase.
                    if (in_valid) begin
                        if (phase_q == rate_q - RATE_W'(1)) begin
                            fire    = 1'b1;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + RATE_W'(1);
                        end
                    end
                    if (fire) begin
                        comb_en_d = 1'b1;
                        // Ratio only changes at a period boundary; uses the pending
                        // value from before any cfg_load in this same cycle.
                        rate_d    = pend_q;
                        if (state_q == PRIME) begin
                            strobe_cnt_d = strobe_cnt_q + CNT_W'(1);
                            if (strobe_cnt_q == CNT_W'(NSTAGES - 1)) begin
                                state_d = RUN;
                            end
                        end else begin
                            dline_d[0] = 1'b1;
                        end
                    end
                    // A newer token replaces an unaccepted one.
                    if (arrive && out_valid_q && !out_ready) begin
                        overrun_d = 1'b1;
                    end
                    out_valid_d = arrive || (out_valid_q && !out_ready);
                end
            endcase
        end

        if (cfg_load) begin
            if (cfg_rate < RATE_W'(2)) begin
                pend_d    = RATE_W'(2);
                cfg_err_d = 1'b1;
            end else begin
                pend_d = cfg_rate;
            end
        end

        integ_clr_d = (state_d == IDLE) || (state_d == FLUSH);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rate_q       <= RATE_W'(2);
            pend_q       <= RATE_W'(2);
            phase_q      <= '0;
            flush_cnt_q  <= '0;
            strobe_cnt_q <= '0;
            dline_q      <= '0;
            integ_en_q   <= 1'b0;
            integ_clr_q  <= 1'b1;
            comb_en_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_q       <= rate_d;
            pend_q       <= pend_d;
            phase_q      <= phase_d;
            flush_cnt_q  <= flush_cnt_d;
            strobe_cnt_q <= strobe_cnt_d;
            dline_q      <= dline_d;
            integ_en_q   <= integ_en_d;
            integ_clr_q  <= integ_clr_d;
            comb_en_q    <= comb_en_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            cfg_err_q    <= cfg_err_d;
            busy_q       <= busy_d;
        end
    end

    assign integ_en  = integ_en_q;
    assign integ_clr = integ_clr_q;
    assign comb_en   = comb_en_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - scoreboard bench for cic_decim_ctrl against a behavioural model
module tb_cic_decim_ctrl;

    localparam int RATE_W   = 8;
    localparam int NSTAGES  = 5;
    localparam int COMB_LAT = 2;
    localparam logic [6:0] RESET_VEC = 7'b0100000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              in_valid = 1'b0;
    logic [RATE_W-1:0] cfg_rate = '0;
    logic              cfg_load = 1'b0;
    logic              out_ready = 1'b0;
    logic              integ_en, integ_clr, comb_en, out_valid, overrun, cfg_err, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cic_decim_ctrl #(.RATE_W(RATE_W), .NSTAGES(NSTAGES), .COMB_LAT(COMB_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .cfg_rate  (cfg_rate),
        .cfg_load  (cfg_load),
        .out_ready (out_ready),
        .integ_en  (integ_en),
        .integ_clr (integ_clr),
        .comb_en   (comb_en),
        .out_valid (out_valid),
        .overrun   (overrun),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    // Expected output vector {integ_en, integ_clr, comb_en, out_valid, overrun, cfg_err, busy}
    logic [6:0] exp_q[$];

    // Behavioural model: mode 0 idle, 1 flush, 2 prime, 3 run.
    int  m_mode = 0, m_flush = 0, m_cnt = 0, m_R = 2, m_pend = 2, m_strobes = 0, m_cyc = 0;
    int  tok[$];
    bit  m_ie = 0, m_ce = 0, m_ov = 0, m_orun = 0, m_cerr = 0, m_arrive = 0;

    always @(posedge clk) begin
        m_cyc++;
        if (!rst) begin
            m_mode = 0; m_R = 2; m_pend = 2; m_cnt = 0; m_strobes = 0; m_flush = 0;
            m_ie = 0; m_ce = 0; m_ov = 0; m_orun = 0; m_cerr = 0;
            tok.delete();
        end else begin
            m_ie = 0;
            m_ce = 0;
            if (!enable) begin
                m_mode = 0;
                m_ov   = 0;
                tok.delete();
            end else if (m_mode == 0) begin
                m_R = m_pend; m_mode = 1; m_flush = 0; m_orun = 0; m_cerr = 0;
            end else if (m_mode == 1) begin
                m_flush++;
                if (m_flush == NSTAGES) begin
                    m_mode = 2; m_cnt = 0; m_strobes = 0;
                end
            end else begin
                m_ie = in_valid;
                if (in_valid) begin
                    m_cnt++;
                    if (m_cnt == m_R) begin
                        m_cnt = 0;
                        m_ce  = 1;
                        m_R   = m_pend;
                        if (m_mode == 3) tok.push_back(m_cyc + COMB_LAT);
                        else begin
                            m_strobes++;
                            if (m_strobes == NSTAGES) m_mode = 3;
                        end
                    end
                end
                m_arrive = (tok.size() > 0) && (tok[0] == m_cyc);
                if (m_arrive) void'(tok.pop_front());
                if (m_arrive && m_ov && !out_ready) m_orun = 1;
                m_ov = m_arrive || (m_ov && !out_ready);
            end
            if (cfg_load) begin
                if (cfg_rate < 2) begin
                    m_pend = 2; m_cerr = 1;
                end else m_pend = int'(cfg_rate);
            end
        end
        exp_q.push_back({m_ie, (m_mode <= 1), m_ce, m_ov, m_orun, m_cerr, (m_mode != 0)});
    end

    // Monitor: pops one expected vector per presented output cycle.
    logic [6:0] e_vec, g_vec;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_vec = exp_q.pop_front();
            if (!rst) e_vec = RESET_VEC;
            g_vec = {integ_en, integ_clr, comb_en, out_valid, overrun, cfg_err, busy};
            total++;
            if (g_vec !== e_vec) begin
                bad++;
                $display("FAIL outputs t=%0t got ie/clr/ce/ov/orun/cerr/busy=%b expected=%b",
                         $time, g_vec, e_vec);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cfg_load = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cfg_rate = 8'd4; cfg_load = 1'b1; tick();
        enable = 1'b1;
        repeat (60) tick();

        cfg_rate = 8'd8; cfg_load = 1'b1; tick();
        for (int i = 0; i < 160; i++) begin
            in_valid = (i % 2) == 0;
            tick();
        end

        in_valid = 1'b1; cfg_rate = 8'd4; cfg_load = 1'b1; tick();
        repeat (41) tick();
        cfg_rate = 8'd3; cfg_load = 1'b1; tick();
        repeat (30) tick();

        cfg_rate = 8'd1; cfg_load = 1'b1; tick();
        repeat (20) tick();

        out_ready = 1'b0; repeat (20) tick();
        out_ready = 1'b1; tick();
        repeat (5) tick();

        out_ready = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL wait_out_valid got=%b expected=1", out_valid);
        end
        enable = 1'b0; tick(); tick();
        enable = 1'b1; out_ready = 1'b1;
        repeat (30) tick();

        for (int i = 0; i < 3000; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 60) == 0) begin
                cfg_load = 1'b1;
                cfg_rate = 8'($urandom_range(0, 7));
            end
            enable = $urandom_range(0, 400) != 0;
            rst    = $urandom_range(0, 1500) != 0;
            tick();
        end

        rst = 1'b1; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cfg_rate = 8'd255; cfg_load = 1'b1; tick();
        enable = 1'b0; tick();
        enable = 1'b1;
        repeat (1800) tick();

        rst = 1'b0; tick(); tick();
        rst = 1'b1; repeat (8) tick();

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
- Sequencer for a CIC decimation filter: integrator chain at input rate, comb chain at decimated rate.
- Generates integrator enable/clear, the decimation strobe (comb_en), pipeline priming and the output valid/ready handshake.
- Sits between the ADC-rate sample stream and the downstream FIR mux.
- Carries no datapath; it drives only the enables of the integrator and comb stages.

Parameters:
- RATE_W, 8, width of the decimation-ratio field.
- NSTAGES, 5, number of integrator/comb stages; sets the flush length and the number of discarded strobes.
- COMB_LAT, 2, cycles from comb_en to valid comb output (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run request; level-sensitive.
- in_valid  in  1  input sample present this cycle.
- cfg_rate  in  RATE_W  decimation ratio R.
- cfg_load  in  1  one-cycle pulse; captures cfg_rate into the pending register.
- out_ready  in  1  downstream accepts the output.
- integ_en  out  1  integrator update enable.
- integ_clr  out  1  synchronous clear of integrator and comb registers.
- comb_en  out  1  decimation strobe; one cycle per R accepted samples.
- out_valid  out  1  decimated output valid.
- overrun  out  1  sticky: an output was lost.
- cfg_err  out  1  sticky: illegal rate loaded.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, except integ_clr=1. State IDLE; rate_reg=2; pending_rate=2; counters 0.
- States: IDLE, FLUSH, PRIME, RUN. All outputs are registered.
- IDLE:
  - integ_clr=1; integ_en=0; comb_en=0; out_valid=0.
  - enable=1 -> load rate_reg from pending_rate, go to FLUSH.
- FLUSH:
  - integ_clr=1 for exactly NSTAGES cycles, then go to PRIME with phase counter 0.
  - integ_en=0 during FLUSH.
- PRIME and RUN:
  - integ_clr=0; integ_en mirrors in_valid one cycle later (registered).
  - Phase counter advances only on in_valid and wraps at rate_reg-1.
  - On in_valid with phase==rate_reg-1: comb_en=1 next cycle, and phase returns to 0.
- PRIME:
  - Count comb strobes. After the NSTAGES-th strobe go to RUN.
  - Outputs of primed strobes are discarded; out_valid stays 0.
- RUN:
  - Each comb_en pushes a token into a COMB_LAT-deep delay line.
  - At the line output, out_valid=1 and is held until out_ready=1 (accepted that cycle; out_valid drops next cycle unless a new token arrives in the same cycle).
  - Token arrives while out_valid=1 and out_ready=0 -> overrun set; out_valid stays 1 (the newer sample replaces the older one).
- Rate config:
  - cfg_load captures cfg_rate into pending_rate. cfg_rate<2 -> load 2 and set cfg_err.
  - In PRIME/RUN, pending_rate is copied into rate_reg only in the cycle a strobe fires (phase boundary).
  - The ratio never changes mid-period. No re-prime on a rate change.
  - cfg_load in the same cycle as a boundary: the new value is applied at the next boundary.
- Disable:
  - enable=0 in any state -> IDLE next cycle.
  - comb_en, out_valid and the delay line are cleared; integ_clr reasserts.
  - The sticky flags are kept.
- Sticky flags: cleared only by reset, or on the IDLE->FLUSH transition.
- Async reset mid-operation: immediate return to the reset values, no strobe glitches.
- rate_reg=2^RATE_W-1: phase counter must not overflow (compare before increment).
- in_valid gaps: phase holds; comb_en timing stretches accordingly.

Test Plan:
- Reset, then enable=1, R=4, in_valid=1 continuous, NSTAGES=5 -> integ_clr high for 5 cycles; comb_en every 4 cycles; first out_valid COMB_LAT cycles after the 6th comb_en.
- RUN with R=8, in_valid toggling 1/0 -> comb_en every 16 cycles; integ_en matches the in_valid pattern delayed by 1.
- Mid-RUN cfg_load R=3 (from 4) at phase 1 -> current period completes at 4 samples; subsequent periods are 3 samples.
- cfg_load cfg_rate=1 -> cfg_err=1; effective R=2.
- out_ready held 0 across two tokens -> overrun=1; out_valid stays 1; one accept clears out_valid.
- enable dropped with out_valid=1 -> next cycle IDLE, out_valid=0, integ_clr=1; re-enable restarts FLUSH and clears the flags.
